// File: rtl/multi_channel_averager_pkg.sv
// Shared types and helpers for the multi-channel block/IIR averager.
package multi_channel_averager_pkg;

    typedef enum logic {MODE_BLOCK = 1'b0, MODE_IIR = 1'b1} mode_e;
    typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_e;

    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned max_log2);
        return dw + max_log2;
    endfunction

    function automatic int unsigned clamp_k(input int unsigned k, input int unsigned max_log2);
        return (k > max_log2) ? max_log2 : k;
    endfunction

endpackage

// File: rtl/multi_channel_averager_if.sv
// Sample-in / average-out bundle of the multi-channel averager.
interface multi_channel_averager_if #(
    parameter int unsigned NCH = 2,
    parameter int unsigned DW  = 16
);
    logic                in_valid;
    logic [NCH*DW-1:0]   in_data;
    logic                out_valid;
    logic [NCH*DW-1:0]   out_data;
    logic                out_mode;
    logic                busy;

    modport master (output in_valid, in_data, input out_valid, out_data, out_mode, busy);
    modport slave  (input in_valid, in_data, output out_valid, out_data, out_mode, busy);
endinterface

// File: rtl/averager_lane.sv
// One channel: accumulator, block/IIR update, shift to output.
// MULTI_CHANNEL_AVERAGER_ROUND_EN selects round-half-up with positive saturation.
module averager_lane
    import multi_channel_averager_pkg::*;
#(
    parameter int unsigned DW       = 16,
    parameter int unsigned MAX_LOG2 = 12,
    parameter int unsigned LW       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 last,
    input  mode_e                mode,
    input  logic [LW-1:0]        k,
    input  logic signed [DW-1:0] x,
    output logic signed [DW-1:0] y
);
    localparam int unsigned ACC_W = acc_width(DW, MAX_LOG2);

    logic signed [ACC_W-1:0] acc_q, acc_d, x_ext, sum_blk, sum_iir, pre;
    logic signed [DW-1:0]    y_q, y_d;

    always_comb begin
        x_ext   = {{MAX_LOG2{x[DW-1]}}, x};
        sum_blk = acc_q + x_ext;
        sum_iir = acc_q + x_ext - (acc_q >>> k);
        pre     = (mode == MODE_IIR) ? sum_iir : sum_blk;
        acc_d   = (mode == MODE_IIR) ? sum_iir : (last ? '0 : sum_blk);
    end

`ifdef MULTI_CHANNEL_AVERAGER_ROUND_EN
    logic signed [ACC_W:0] bias, rnd;
    always_comb begin
        bias = (k == '0) ? '0 : ((ACC_W+1)'(1) << (k - LW'(1)));
        rnd  = ({pre[ACC_W-1], pre} + bias) >>> k;
        // Only the positive side can exceed the output range after rounding up
        if (!rnd[ACC_W] && (rnd[ACC_W-1:DW-1] != '0)) begin
            y_d = {1'b0, {(DW-1){1'b1}}};
        end else begin
            y_d = rnd[DW-1:0];
        end
    end
`else
    logic signed [ACC_W-1:0] shr;
    always_comb begin
        shr = pre >>> k;
        y_d = shr[DW-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            y_q   <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
            if (mode == MODE_IIR || last) y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/multi_channel_averager.sv
// NCH-channel block/IIR averager: FSM, block counter, parameter latching, out_valid.
// Optional rounding in the lanes via MULTI_CHANNEL_AVERAGER_ROUND_EN.
module multi_channel_averager
    import multi_channel_averager_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned DW       = 16,
    parameter int unsigned MAX_LOG2 = 12,
    parameter int unsigned LW       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sync_i,
    input  logic                     mode,
    input  logic [LW-1:0]            log2_len,
    multi_channel_averager_if.slave  bus
);
    localparam int unsigned CW = MAX_LOG2 + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] k_q, k_d, k_in, k_eff;
    mode_e         mode_q, mode_d, mode_in, mode_eff;
    logic          out_valid_q, out_valid_d, out_mode_q, out_mode_d;
    logic          blk_last, fire;

    always_comb begin
        k_in     = LW'(clamp_k({{(32-LW){1'b0}}, log2_len}, MAX_LOG2));
        mode_in  = mode_e'(mode);
        // IDLE follows the ports live so the first sample uses this cycle's settings
        k_eff    = (state_q == ST_IDLE) ? k_in : k_q;
        mode_eff = (state_q == ST_IDLE) ? mode_in : mode_q;
        blk_last = (cnt_q == ((CW'(1) << k_eff) - CW'(1)));
        fire     = bus.in_valid && !sync_i;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        mode_d      = mode_q;
        out_valid_d = 1'b0;
        out_mode_d  = out_mode_q;
        if (sync_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            k_d     = k_in;
            mode_d  = mode_in;
        end else begin
            if (state_q == ST_IDLE) begin
                k_d    = k_in;
                mode_d = mode_in;
            end
            if (bus.in_valid) begin
                state_d = ST_ACCUM;
                if (mode_eff == MODE_IIR) begin
                    out_valid_d = 1'b1;
                    out_mode_d  = 1'b1;
                end else if (blk_last) begin
                    out_valid_d = 1'b1;
                    out_mode_d  = 1'b0;
                    cnt_d       = '0;
                    k_d         = k_in;
                    mode_d      = mode_in;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            mode_q      <= MODE_BLOCK;
            out_valid_q <= 1'b0;
            out_mode_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_mode_q  <= out_mode_d;
        end
    end

    logic signed [DW-1:0] lane_y [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        averager_lane #(
            .DW       (DW),
            .MAX_LOG2 (MAX_LOG2),
            .LW       (LW)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .clr  (sync_i),
            .en   (fire),
            .last (blk_last),
            .mode (mode_eff),
            .k    (k_eff),
            .x    (bus.in_data[c*DW +: DW]),
            .y    (lane_y[c])
        );
    end

    always_comb begin
        bus.out_data = '0;
        for (int c = 0; c < NCH; c++) bus.out_data[c*DW +: DW] = lane_y[c];
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_mode  = out_mode_q;
    assign bus.busy      = (state_q == ST_ACCUM) && (cnt_q != '0);

endmodule

// File: tb/tb_multi_channel_averager.sv
// Randomized + directed bench for multi_channel_averager against a transaction-level model.
module tb_multi_channel_averager;
    localparam int unsigned NCH = 2, DW = 16, MAX_LOG2 = 12, LW = 4;

    logic          clk = 1'b0;
    logic          rst, sync_i, mode;
    logic [LW-1:0] log2_len;

    always #5 clk = ~clk;

    multi_channel_averager_if #(.NCH(NCH), .DW(DW)) bus ();

    multi_channel_averager #(
        .NCH(NCH), .DW(DW), .MAX_LOG2(MAX_LOG2), .LW(LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sync_i   (sync_i),
        .mode     (mode),
        .log2_len (log2_len),
        .bus      (bus)
    );

    int n_tests = 0, n_fail = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: blocks are kept as a list of samples and averaged when complete
    bit                m_idle = 1'b1, m_mode = 1'b0;
    int                m_k = 0;
    logic [NCH*DW-1:0] blkq[$];
    longint            iir_acc[NCH];
    bit                e_valid = 1'b0, e_mode = 1'b0, e_busy = 1'b0;
    longint            e_data[NCH];

    function automatic longint floor_div(input longint a, input int k);
        longint d = longint'(1) << k;
        return (a >= 0) ? a / d : -((-a + d - 1) / d);
    endfunction

    function automatic longint scale_out(input longint s, input int k);
`ifdef MULTI_CHANNEL_AVERAGER_ROUND_EN
        longint r = (k > 0) ? floor_div(s + (longint'(1) << (k - 1)), k) : s;
        return (r > 32767) ? 32767 : r;
`else
        return floor_div(s, k);
`endif
    endfunction

    function automatic longint chan(input logic [NCH*DW-1:0] v, input int c);
        return longint'($signed(v[c*DW +: DW]));
    endfunction

    task automatic model_step();
        int k_port = (int'(log2_len) > MAX_LOG2) ? MAX_LOG2 : int'(log2_len);
        e_valid = 1'b0;
        if (rst) begin
            m_idle = 1'b1; m_k = 0; m_mode = 1'b0; e_mode = 1'b0;
            blkq.delete();
            for (int c = 0; c < NCH; c++) begin iir_acc[c] = 0; e_data[c] = 0; end
        end else if (sync_i) begin
            m_idle = 1'b1; m_k = k_port; m_mode = mode;
            blkq.delete();
            for (int c = 0; c < NCH; c++) iir_acc[c] = 0;
        end else begin
            if (m_idle) begin m_k = k_port; m_mode = mode; end
            if (bus.in_valid) begin
                m_idle = 1'b0;
                if (m_mode) begin
                    for (int c = 0; c < NCH; c++) begin
                        iir_acc[c] = iir_acc[c] + chan(bus.in_data, c) - floor_div(iir_acc[c], m_k);
                        e_data[c]  = scale_out(iir_acc[c], m_k);
                    end
                    e_valid = 1'b1; e_mode = 1'b1;
                end else begin
                    blkq.push_back(bus.in_data);
                    if (blkq.size() == (1 << m_k)) begin
                        for (int c = 0; c < NCH; c++) begin
                            longint s = 0;
                            foreach (blkq[i]) s += chan(blkq[i], c);
                            e_data[c] = scale_out(s, m_k);
                        end
                        e_valid = 1'b1; e_mode = 1'b0;
                        blkq.delete();
                        m_k = k_port; m_mode = mode;
                    end
                end
            end
        end
        e_busy = !m_idle && (blkq.size() > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("out_valid", longint'(bus.out_valid), longint'(e_valid));
        check_eq("busy", longint'(bus.busy), longint'(e_busy));
        check_eq("out_mode", longint'(bus.out_mode), longint'(e_mode));
        for (int c = 0; c < NCH; c++)
            check_eq($sformatf("out_data[%0d]", c), chan(bus.out_data, c), e_data[c]);
    endtask

    task automatic send(input bit v, input longint d0, input longint d1);
        logic [DW-1:0] a, b;
        a = d0[DW-1:0];
        b = d1[DW-1:0];
        bus.in_valid = v;
        bus.in_data  = {b, a};
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_sync(input bit m, input logic [LW-1:0] l);
        mode = m; log2_len = l; sync_i = 1'b1;
        send(0, 0, 0);
        sync_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sync_i = 1'b0; mode = 1'b0; log2_len = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        tick(); tick();
        check_eq("rst_out_data0", chan(bus.out_data, 0), 0);
        rst = 1'b0;

        // Block k=2: 4,8,12,16 / -1,-1,-1,-2
        do_sync(0, 2);
        send(1, 4, -1); send(1, 8, -1); send(1, 12, -1);
        check_eq("blk_busy", longint'(bus.busy), 1);
        send(1, 16, -2);
        check_eq("blk_valid", longint'(bus.out_valid), 1);
        check_eq("blk_ch0", chan(bus.out_data, 0), 10);
`ifdef MULTI_CHANNEL_AVERAGER_ROUND_EN
        check_eq("blk_ch1", chan(bus.out_data, 1), -1);
`else
        check_eq("blk_ch1", chan(bus.out_data, 1), -2);
`endif
        send(0, 0, 0);

        // Full scale k=12 negative, then log2_len=15 clamped with positive full scale
        do_sync(0, 12);
        for (int i = 0; i < 4096; i++) send(1, -32768, 0);
        check_eq("fs_neg", chan(bus.out_data, 0), -32768);
        do_sync(0, 15);
        for (int i = 0; i < 4096; i++) send(1, 32767, 0);
        check_eq("fs_pos_valid", longint'(bus.out_valid), 1);
        check_eq("fs_pos", chan(bus.out_data, 0), 32767);

        // IIR k=1 step response
        do_sync(1, 1);
        send(1, 0, 0);
        send(1, 100, 0); check_eq("iir_50", chan(bus.out_data, 0), 50);
        send(1, 100, 0); check_eq("iir_75", chan(bus.out_data, 0), 75);
        send(1, 100, 0);
`ifdef MULTI_CHANNEL_AVERAGER_ROUND_EN
        check_eq("iir_88", chan(bus.out_data, 0), 88);
`else
        check_eq("iir_87", chan(bus.out_data, 0), 87);
`endif

        // log2_len change mid-block is deferred to the next block
        do_sync(0, 2);
        send(1, 1, 1); send(1, 2, 2);
        log2_len = 3;
        send(1, 3, 3); send(1, 4, 4);
        check_eq("khold_close4", longint'(bus.out_valid), 1);
        for (int i = 0; i < 7; i++) send(1, i, -i);
        check_eq("knew_open", longint'(bus.out_valid), 0);
        send(1, 9, 9);
        check_eq("knew_close8", longint'(bus.out_valid), 1);

        // sync coincident with the 3rd valid
        do_sync(0, 2);
        send(1, 100, 100); send(1, 200, 200);
        sync_i = 1'b1; send(1, 300, 300); sync_i = 1'b0;
        check_eq("sync_busy", longint'(bus.busy), 0);
        send(1, 1, -5); send(1, 2, -6); send(1, 3, -7); send(1, 6, -8);
        check_eq("sync_ch0", chan(bus.out_data, 0), 3);

        // Reset mid-block and mid-IIR
        send(1, 50, 50); send(1, 60, 60);
        rst = 1'b1; send(0, 0, 0); rst = 1'b0;
        check_eq("rst_blk_data", chan(bus.out_data, 0), 0);
        mode = 1'b1; log2_len = 2;
        send(1, 40, 40); send(1, 40, 40);
        rst = 1'b1; send(0, 0, 0); rst = 1'b0;
        check_eq("rst_iir_mode", longint'(bus.out_mode), 0);
        mode = 1'b0; log2_len = 0;
        send(1, 7, -7);
        check_eq("rst_fresh", chan(bus.out_data, 0), 7);

        // Random traffic
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 99) < 3) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 5)
                log2_len = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(0, 15))
                                                       : LW'($urandom_range(0, 3));
            sync_i = ($urandom_range(0, 99) < 2);
            rst    = ($urandom_range(0, 999) < 3);
            send(($urandom_range(0, 99) < 70), longint'($signed(16'($urandom))),
                 longint'($signed(16'($urandom))));
            sync_i = 1'b0;
            rst    = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_channel_averager.md
Name: multi_channel_averager

Overview:
- Parametrised successor to the single-channel summation/IIR averaging blocks: NCH independent signed channels with shared timing and a runtime-selectable mode.
- Modes: block average (sum 2^k samples, emit mean once per block, decimating) or first-order IIR (exponential average, emits on every input sample).
- Sits between the ADC/demodulator sample path and the lock-loop/AXI readout; output drives PID error inputs or status registers.

Parameters:
- NCH, 2, number of channels sharing in_valid and timing.
- DW, 16, signed sample width per channel (input and output).
- MAX_LOG2, 12, largest supported averaging exponent k; sets accumulator width ACC_W = DW + MAX_LOG2.
- LW, 4, width of the runtime log2_len port; must satisfy 2^LW > MAX_LOG2.

Ports:
- clk  in  1  sample clock.
- rst  in  1  synchronous reset, active-high.
- sync_i  in  1  clears accumulators and block counter; restarts phase alignment.
- mode  in  1  0 = block average, 1 = IIR.
- log2_len  in  LW  requested exponent k; values above MAX_LOG2 are clamped to MAX_LOG2.
- in_valid  in  1  qualifies in_data for one cycle.
- in_data  in  NCH*DW  packed signed samples; channel c occupies [c*DW +: DW].
- out_valid  out  1  one-cycle strobe qualifying out_data.
- out_data  out  NCH*DW  packed signed averages.
- out_mode  out  1  mode that produced the current out_data.
- busy  out  1  high while a block is partially accumulated (state ACCUM with cnt > 0).

Behaviour:
- All arithmetic is two's complement. Inputs are sign-extended from the true MSB to ACC_W; the MSB is never dropped.
- Reset (rst=1 at a clk edge): state=IDLE, all accumulators=0, cnt=0, out_data=0, out_valid=0, out_mode=0, busy=0, latched k=0, latched mode=0. Reset mid-block discards the partial sum.
- States: IDLE, ACCUM.
  - IDLE: on each cycle latch k_l = clamp(log2_len) and mode_l = mode. On the first in_valid, go to ACCUM and process that sample as sample 0.
  - ACCUM: process each in_valid sample per mode_l. k_l and mode_l are re-latched only at a block boundary (block mode) or when returning to IDLE. Changes on the ports mid-block are ignored until then.
  - sync_i=1: go to IDLE, zero accumulators and cnt, out_valid=0 that cycle. sync_i has priority over a coincident in_valid; that sample is discarded.
- Block mode (mode_l=0):
  - On valid, acc_c <= acc_c + x_c and cnt <= cnt + 1.
  - On the valid carrying sample index 2^k_l - 1: register out_c = (acc_c + x_c) >>> k_l, truncated toward -inf. Clear acc to 0 and cnt to 0, re-latch k_l/mode_l, and pulse out_valid on the next cycle (latency 1 from the final in_valid).
  - k_l=0: every sample is passed through with latency 1.
  - cnt is MAX_LOG2+1 bits and cannot wrap.
- IIR mode (mode_l=1):
  - On valid, acc_c <= acc_c + x_c - (acc_c >>> k_l).
  - out_c = acc_new >>> k_l is registered in the same edge; out_valid pulses 1 cycle after every in_valid.
  - acc is a scaled mean, bounded by ACC_W; no overflow is possible.
  - k_l=0 gives out = x (latency 1).
- out_valid is never asserted for two samples' worth in one cycle; out_data holds its value between strobes.
- Full-scale check: block of 2^MAX_LOG2 samples at -2^(DW-1) fits exactly in ACC_W.

Optional Feature:
- Macro: MULTI_CHANNEL_AVERAGER_ROUND_EN.
- Defined: before the shift, add 2^(k_l-1) for k_l>0 (round half up). If the rounded result exceeds 2^(DW-1)-1, saturate to 2^(DW-1)-1.
- Undefined: plain arithmetic-shift truncation, no saturation logic.

Decomposition:
- Shared package holds:
  - ACC_W derivation function;
  - clamp-to-MAX_LOG2 function;
  - mode encodings (MODE_BLOCK=0, MODE_IIR=1);
  - state encodings (ST_IDLE, ST_ACCUM).
- Sub-module: averager_lane — one channel's accumulator, update mux, shift and optional rounding, instantiated NCH times by generate.
- Top level owns the FSM, counter, latching and out_valid.

Test Plan:
- Block mode, NCH=2, k=2, ch0 samples 4,8,12,16 and ch1 -1,-1,-1,-2 on consecutive valids -> one out_valid 1 cycle after the 4th valid, out ch0=10, ch1=-2 (truncated; -1 with ROUND_EN).
- Block mode k=12, 4096 samples of -32768 on ch0 -> ch0=-32768, no wrap. Repeat with +32767 -> 32767.
- IIR mode, k=1, step input 0 then constant 100 -> acc sequence 100,150,175,… and out 50,75,87,… each 1 cycle after valid; out_valid on every valid.
- log2_len changed from 2 to 3 after the 2nd sample of a block -> current block still closes after 4 samples, next block closes after 8. log2_len=15 -> behaves as k=12.
- sync_i coincident with the 3rd in_valid of a k=2 block -> no out_valid, busy=0. The next 4 valids produce one average of those 4 only.
- rst asserted mid-block and mid-IIR -> next cycle all outputs 0, state IDLE, and the first post-reset sample starts a fresh block.
